// File: rtl/mor1kx_sdpram_be_sclk.sv
// Single-clock simple dual-port RAM with byte-lane writes, lane-merged
// write-to-read bypass, optional output register and a hardware zero sweep.
module mor1kx_sdpram_be_sclk #(
   parameter int ADDR_WIDTH     = 6,
   parameter int DATA_WIDTH     = 32,
   parameter int BYTE_WIDTH     = 8,
   parameter int ENABLE_BYPASS  = 1,
   parameter int OUTPUT_REG     = 0,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                clr,
   output logic                                busy,
   input  logic [ADDR_WIDTH-1:0]               raddr,
   input  logic                                re,
   input  logic [ADDR_WIDTH-1:0]               waddr,
   input  logic                                we,
   input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]    be,
   input  logic [DATA_WIDTH-1:0]               din,
   output logic [DATA_WIDTH-1:0]               dout,
   output logic                                dout_valid
);

   localparam int NB    = DATA_WIDTH / BYTE_WIDTH;
   localparam int DEPTH = 1 << ADDR_WIDTH;

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t                  state_q;
   logic [ADDR_WIDTH-1:0]   cnt_q;
   logic [DATA_WIDTH-1:0]   mem [DEPTH];

   logic                    acc, rd_acc, wr_acc;

   logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
   logic [DATA_WIDTH-1:0]   din_r_q, din_r_d;
   logic [NB-1:0]           be_r_q, be_r_d;
   logic                    byp_q, byp_d;
   logic                    rd_vld_q, rd_vld_d;
   logic [DATA_WIDTH-1:0]   s1_res;

   // clr takes priority over a same-cycle access, which is dropped
   assign acc    = (state_q == IDLE) && !clr;
   assign rd_acc = acc && re;
   assign wr_acc = acc && we;
   assign busy   = (state_q == CLEAR);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         state_q <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (clr) begin
                  cnt_q   <= '0;
                  state_q <= CLEAR;
               end
            end
            CLEAR: begin
               cnt_q <= cnt_q + ADDR_WIDTH'(1);
               if (cnt_q == '1)
                  state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Array has no reset; the sweep is the only way it gets cleared
   always_ff @(posedge clk) begin
      if (rst_n) begin
         if (state_q == CLEAR) begin
            mem[cnt_q] <= '0;
         end else if (wr_acc) begin
            for (int i = 0; i < NB; i++)
               if (be[i])
                  mem[waddr][i*BYTE_WIDTH +: BYTE_WIDTH] <= din[i*BYTE_WIDTH +: BYTE_WIDTH];
         end
      end
   end

   always_comb begin
      rdata_d  = rdata_q;
      din_r_d  = din_r_q;
      be_r_d   = be_r_q;
      byp_d    = byp_q;
      rd_vld_d = rd_acc;
      if (rd_acc) begin
         rdata_d = mem[raddr];
         din_r_d = din;
         be_r_d  = be;
         byp_d   = (ENABLE_BYPASS != 0) && we && (raddr == waddr);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rdata_q  <= '0;
         din_r_q  <= '0;
         be_r_q   <= '0;
         byp_q    <= 1'b0;
         rd_vld_q <= 1'b0;
      end else begin
         rdata_q  <= rdata_d;
         din_r_q  <= din_r_d;
         be_r_q   <= be_r_d;
         byp_q    <= byp_d;
         rd_vld_q <= rd_vld_d;
      end
   end

   // Lanes written in the same cycle as the read replace the stale array data
   always_comb begin
      s1_res = rdata_q;
      for (int i = 0; i < NB; i++)
         if (byp_q && be_r_q[i])
            s1_res[i*BYTE_WIDTH +: BYTE_WIDTH] = din_r_q[i*BYTE_WIDTH +: BYTE_WIDTH];
   end

   generate
      if (OUTPUT_REG != 0) begin : g_oreg
         logic [DATA_WIDTH-1:0] dout_q, dout_d;
         logic                  out_vld_q, out_vld_d;

         always_comb begin
            dout_d    = rd_vld_q ? s1_res : dout_q;
            out_vld_d = rd_vld_q;
         end

         always_ff @(posedge clk) begin
            if (!rst_n) begin
               dout_q    <= '0;
               out_vld_q <= 1'b0;
            end else begin
               dout_q    <= dout_d;
               out_vld_q <= out_vld_d;
            end
         end

         assign dout       = dout_q;
         assign dout_valid = out_vld_q;
      end else begin : g_noreg
         assign dout       = s1_res;
         assign dout_valid = rd_vld_q;
      end
   endgenerate

endmodule
